// File: rtl/registers_if.sv
// registers_if: read/write port bundle between decode/write-back and the register file
interface registers_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] Rr1;
    logic [ADDR_WIDTH-1:0] Rr2;
    logic [ADDR_WIDTH-1:0] WriteRegister;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  regWrite;
    logic [DATA_WIDTH-1:0] Rd1;
    logic [DATA_WIDTH-1:0] Rd2;
    modport master (output Rr1, Rr2, WriteRegister, WriteData, regWrite, input Rd1, Rd2);
    modport slave  (input Rr1, Rr2, WriteRegister, WriteData, regWrite, output Rd1, Rd2);
endinterface

// File: rtl/registers.sv
// registers: 2-read/1-write register file with r0 hardwired to zero and async active-low clear
module registers #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic        clk,
    input logic        rst,
    registers_if.slave bus
);
    logic [DATA_WIDTH-1:0] r [2**ADDR_WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2**ADDR_WIDTH; i++) r[i] <= '0;
        end else if (bus.regWrite && bus.WriteRegister != '0) begin
            r[bus.WriteRegister] <= bus.WriteData;
        end
    end

    // r0 and the held-in-reset state both read as zero without relying on array contents
    assign bus.Rd1 = (rst && bus.Rr1 != '0) ? r[bus.Rr1] : '0;
    assign bus.Rd2 = (rst && bus.Rr2 != '0) ? r[bus.Rr2] : '0;
endmodule

// File: tb/tb_registers.sv
// tb_registers: directed and randomized checks of the register file against an array model
module tb_registers;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0] model [32];

    registers_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
    registers #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    task automatic step(input logic we, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.regWrite = we;
        bus.WriteRegister = a;
        bus.WriteData = d;
        @(posedge clk);
        #1;
        if (we && a != 0 && rst) model[a] = d;
        bus.regWrite = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        for (int i = 0; i < 4; i++) begin
            bus.Rr1 = 5'($urandom);
            bus.Rr2 = 5'($urandom);
            #1;
            checks++;
            if (bus.Rd1 !== 32'h0 || bus.Rd2 !== 32'h0) begin
                errors++;
                $display("FAIL reset_read: Rd1=%h Rd2=%h expected 0", bus.Rd1, bus.Rd2);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        clear_model();
    endtask

    task automatic test_seq_write();
        step(1'b1, 5'd1, 32'h2);
        step(1'b1, 5'd2, 32'h3);
        bus.Rr1 = 5'd2;
        bus.Rr2 = 5'd1;
        #1;
        checks++;
        if (bus.Rd1 !== 32'h3 || bus.Rd2 !== 32'h2) begin
            errors++;
            $display("FAIL seq_write: Rd1=%h Rd2=%h expected 3 2", bus.Rd1, bus.Rd2);
        end
    endtask

    task automatic test_we_gate();
        step(1'b0, 5'd9, 32'h5);
        bus.Rr1 = 5'd9;
        #1;
        checks++;
        if (bus.Rd1 !== 32'h0) begin
            errors++;
            $display("FAIL we_gate: Rd1=%h expected 0", bus.Rd1);
        end
    endtask

    task automatic test_overwrite();
        step(1'b1, 5'd3, 32'hF);
        step(1'b1, 5'd1, 32'hB);
        bus.Rr1 = 5'd1;
        bus.Rr2 = 5'd3;
        #1;
        checks++;
        if (bus.Rd1 !== 32'hB || bus.Rd2 !== 32'hF) begin
            errors++;
            $display("FAIL overwrite: Rd1=%h Rd2=%h expected b f", bus.Rd1, bus.Rd2);
        end
    endtask

    task automatic test_r0();
        step(1'b1, 5'd0, 32'hFFFF_FFFF);
        bus.Rr1 = 5'd0;
        bus.Rr2 = 5'd0;
        #1;
        checks++;
        if (bus.Rd1 !== 32'h0 || bus.Rd2 !== 32'h0) begin
            errors++;
            $display("FAIL r0_hardwired: Rd1=%h Rd2=%h expected 0", bus.Rd1, bus.Rd2);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 5'd5, 32'hAAAA_0001);
        step(1'b1, 5'd5, 32'h5555_0002);
        bus.Rr1 = 5'd5;
        bus.Rr2 = 5'd5;
        #1;
        checks++;
        if (bus.Rd1 !== 32'h5555_0002 || bus.Rd2 !== 32'h5555_0002) begin
            errors++;
            $display("FAIL back_to_back: Rd1=%h Rd2=%h expected 55550002", bus.Rd1, bus.Rd2);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 5'd1, 32'hB);
        bus.Rr1 = 5'd1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.Rd1 !== 32'hB) begin
            errors++;
            $display("FAIL pre_reset: Rd1=%h expected b", bus.Rd1);
        end
        // a write is pending across the edge that falls inside the reset pulse
        bus.regWrite = 1'b1;
        bus.WriteRegister = 5'd7;
        bus.WriteData = 32'h1234_5678;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.Rd1 !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: Rd1=%h expected 0 before any edge", bus.Rd1);
        end
        clear_model();
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.regWrite = 1'b0;
        rst = 1'b1;
        for (int a = 0; a < 32; a++) begin
            bus.Rr1 = 5'(a);
            bus.Rr2 = 5'(31 - a);
            #1;
            checks++;
            if (bus.Rd1 !== model[a] || bus.Rd2 !== model[31 - a]) begin
                errors++;
                $display("FAIL post_reset r%0d: Rd1=%h Rd2=%h expected 0", a, bus.Rd1, bus.Rd2);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] a, r2;
        logic [31:0] d, old;
        logic we;
        for (int n = 0; n < 300; n++) begin
            we = ($urandom_range(3) != 0);
            a = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom);
            d = $urandom;
            r2 = 5'($urandom);
            @(negedge clk);
            bus.regWrite = we;
            bus.WriteRegister = a;
            bus.WriteData = d;
            bus.Rr1 = a;
            bus.Rr2 = r2;
            old = model[a];
            #1;
            checks++;
            if (bus.Rd1 !== old || bus.Rd2 !== model[r2]) begin
                errors++;
                $display("FAIL rand_pre n=%0d: Rd1=%h Rd2=%h expected %h %h", n, bus.Rd1, bus.Rd2, old, model[r2]);
            end
            @(posedge clk);
            #1;
            if (we && a != 0) model[a] = d;
            checks++;
            if (bus.Rd1 !== model[a] || bus.Rd2 !== model[r2]) begin
                errors++;
                $display("FAIL rand_post n=%0d: Rd1=%h Rd2=%h expected %h %h", n, bus.Rd1, bus.Rd2, model[a], model[r2]);
            end
            bus.regWrite = 1'b0;
        end
    endtask

    initial begin
        bus.Rr1 = '0;
        bus.Rr2 = '0;
        bus.WriteRegister = '0;
        bus.WriteData = '0;
        bus.regWrite = 1'b0;
        clear_model();
        test_reset();
        test_seq_write();
        test_we_gate();
        test_overwrite();
        test_r0();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
